// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state enum, opcode/op constants and control encodings for the SimpleRISC sequencer
package cpu_pkg;
   typedef enum logic [4:0] {
      S_RESET, S_IF, S_IF_LATCH, S_PC_INC, S_DECODE,
      S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_EXEC_CMP, S_EXEC_PASS, S_WR_RD,
      S_ADDR, S_LD_ADDR, S_MEM_RD, S_MEM_RD_LATCH, S_GET_RD, S_PASS_B, S_MEM_WR,
      S_HALT
   } state_t;
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_LDR = 3'b011;
   localparam logic [2:0] OPC_STR = 3'b100;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_MVN = 2'b11;
   localparam logic [1:0] OP_MEM = 2'b00;
   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN = 3'b100;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b001;
   localparam logic [1:0] VSEL_C = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;
   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_READ = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute Moore sequencer for the SimpleRISC CPU
module cpu_sequencer
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic       mem_ready,
   output logic       reset_pc,
   output logic       load_pc,
   output logic       addr_sel,
   output logic       load_ir,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       loada,
   output logic       loadb,
   output logic       asel,
   output logic       bsel,
   output logic       loadc,
   output logic       loads,
   output logic       write,
   output logic       halted
);
   state_t state, next;

   // state register; reset low abandons any instruction or memory wait at once
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= S_RESET;
      else state <= next;

   // next state; opcode/op are stable from the IR for the whole instruction after IF_LATCH
   always_comb begin
      next = state;
      case (state)
         S_RESET:        next = S_IF;
         S_IF:           next = mem_ready ? S_IF_LATCH : S_IF;
         S_IF_LATCH:     next = S_PC_INC;
         S_PC_INC:       next = S_DECODE;
         S_DECODE:
            if (opcode == OPC_MOV && op == OP_MOV_IMM) next = S_WR_IMM;
            else if ((opcode == OPC_MOV && op == OP_MOV_REG) || (opcode == OPC_ALU && op == OP_MVN)) next = S_GET_B;
            else if (opcode == OPC_ALU || ((opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM)) next = S_GET_A;
            else next = S_HALT;
         S_GET_A:        next = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
         S_GET_B:        next = (opcode == OPC_MOV || op == OP_MVN) ? S_EXEC_PASS : (op == OP_CMP ? S_EXEC_CMP : S_EXEC);
         S_EXEC:         next = S_WR_RD;
         S_EXEC_PASS:    next = S_WR_RD;
         S_EXEC_CMP:     next = S_IF;
         S_WR_RD:        next = S_IF;
         S_WR_IMM:       next = S_IF;
         S_ADDR:         next = S_LD_ADDR;
         S_LD_ADDR:      next = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_RD;
         S_MEM_RD:       next = mem_ready ? S_MEM_RD_LATCH : S_MEM_RD;
         S_MEM_RD_LATCH: next = S_IF;
         S_GET_RD:       next = S_PASS_B;
         S_PASS_B:       next = S_MEM_WR;
         S_MEM_WR:       next = mem_ready ? S_IF : S_MEM_WR;
         S_HALT:         next = S_HALT;
         default:        next = S_RESET;
      endcase
   end

   // Moore output decode from the state register alone
   always_comb begin
      reset_pc = 1'b0;
      load_pc = 1'b0;
      addr_sel = 1'b0;
      load_ir = 1'b0;
      load_addr = 1'b0;
      mem_cmd = CMD_NONE;
      nsel = NSEL_NONE;
      vsel = VSEL_C;
      loada = 1'b0;
      loadb = 1'b0;
      asel = 1'b0;
      bsel = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
      write = 1'b0;
      halted = 1'b0;
      case (state)
         S_RESET: begin
            reset_pc = 1'b1;
            load_pc = 1'b1;
         end
         S_IF: begin
            addr_sel = 1'b1;
            mem_cmd = CMD_READ;
         end
         S_IF_LATCH: begin
            addr_sel = 1'b1;
            mem_cmd = CMD_READ;
            load_ir = 1'b1;
         end
         S_PC_INC: load_pc = 1'b1;
         S_WR_IMM: begin
            nsel = NSEL_RN;
            vsel = VSEL_IMM;
            write = 1'b1;
         end
         S_GET_A: begin
            nsel = NSEL_RN;
            loada = 1'b1;
         end
         S_GET_B: begin
            nsel = NSEL_RM;
            loadb = 1'b1;
         end
         S_EXEC: loadc = 1'b1;
         S_EXEC_CMP: loads = 1'b1;
         S_EXEC_PASS: begin
            asel = 1'b1;
            loadc = 1'b1;
         end
         S_WR_RD: begin
            nsel = NSEL_RD;
            vsel = VSEL_C;
            write = 1'b1;
         end
         S_ADDR: begin
            bsel = 1'b1;
            loadc = 1'b1;
         end
         S_LD_ADDR: load_addr = 1'b1;
         S_MEM_RD: mem_cmd = CMD_READ;
         S_MEM_RD_LATCH: begin
            mem_cmd = CMD_READ;
            nsel = NSEL_RD;
            vsel = VSEL_MDATA;
            write = 1'b1;
         end
         S_GET_RD: begin
            nsel = NSEL_RD;
            loadb = 1'b1;
         end
         S_PASS_B: begin
            asel = 1'b1;
            loadc = 1'b1;
         end
         S_MEM_WR: mem_cmd = CMD_WRITE;
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream checked cycle by cycle against a per-instruction step plan
module tb_cpu_sequencer;
   localparam logic [19:0] RPC = 20'h80000, LPC = 20'h40000, ASL = 20'h20000, LIR = 20'h10000;
   localparam logic [19:0] LAD = 20'h08000, CWR = 20'h04000, CRD = 20'h02000;
   localparam logic [19:0] NRN = 20'h01000, NRD = 20'h00800, NRM = 20'h00400;
   localparam logic [19:0] VIMM = 20'h00200, VMD = 20'h00300;
   localparam logic [19:0] LA = 20'h00080, LB = 20'h00040, AS = 20'h00020, BS = 20'h00010;
   localparam logic [19:0] LC = 20'h00008, LS = 20'h00004, WR = 20'h00002, HLT = 20'h00001;

   typedef struct packed {
      logic rn;
      logic rdy;
      logic [2:0] opc;
      logic [1:0] op;
      logic [19:0] v;
   } step_t;

   logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic [1:0] op = 2'b00;
   logic reset_pc, load_pc, addr_sel, load_ir, load_addr, loada, loadb, asel, bsel, loadc, loads, write, halted;
   logic [1:0] mem_cmd, vsel;
   logic [2:0] nsel;
   logic [19:0] act;
   step_t plan[$];
   step_t cur;
   logic chk = 1'b0;
   logic [2:0] c_opc;
   logic [1:0] c_op;
   logic halts;
   int checks = 0, failures = 0, cyc = 0;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
      .reset_pc(reset_pc), .load_pc(load_pc), .addr_sel(addr_sel), .load_ir(load_ir),
      .load_addr(load_addr), .mem_cmd(mem_cmd), .nsel(nsel), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
      .loads(loads), .write(write), .halted(halted)
   );

   assign act = {reset_pc, load_pc, addr_sel, load_ir, load_addr, mem_cmd, nsel, vsel,
                 loada, loadb, asel, bsel, loadc, loads, write, halted};

   always #5 clk = ~clk;

   // every planned cycle: DUT outputs must equal the plan's expected vector
   always @(negedge clk) begin
      if (chk) begin
         checks++;
         if (act !== cur.v) begin
            failures++;
            $display("FAIL cycle%0d outputs opc=%b op=%b got=%05h want=%05h", cyc, cur.opc, cur.op, act, cur.v);
         end
      end
   end

   task automatic pin(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic put(input logic [19:0] v, input logic rdy);
      plan.push_back('{rn: 1'b1, rdy: rdy, opc: c_opc, op: c_op, v: v});
   endtask

   task automatic one(input logic [19:0] v);
      put(v, 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_st(input logic [19:0] v, input int n);
      repeat (n) put(v, 1'b0);
      put(v, 1'b1);
   endtask

   task automatic rst();
      plan.push_back('{rn: 1'b0, rdy: 1'b0, opc: c_opc, op: c_op, v: RPC | LPC});
      plan.push_back('{rn: 1'b1, rdy: 1'b0, opc: c_opc, op: c_op, v: RPC | LPC});
   endtask

   // one instruction: fetch with ifw stall cycles, then the class-specific steps with mw stalls on the data access
   task automatic add(input logic [2:0] opc, input logic [1:0] o, input int ifw, input int mw);
      c_opc = opc;
      c_op = o;
      halts = 1'b0;
      wait_st(ASL | CRD, ifw);
      one(ASL | CRD | LIR);
      one(LPC);
      one(20'h0);
      if (opc == 3'b110 && o == 2'b10) one(NRN | VIMM | WR);
      else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
         one(NRM | LB); one(AS | LC); one(NRD | WR);
      end else if (opc == 3'b101) begin
         one(NRN | LA); one(NRM | LB);
         if (o == 2'b01) one(LS);
         else begin one(LC); one(NRD | WR); end
      end else if (opc == 3'b011 && o == 2'b00) begin
         one(NRN | LA); one(BS | LC); one(LAD); wait_st(CRD, mw); one(CRD | NRD | VMD | WR);
      end else if (opc == 3'b100 && o == 2'b00) begin
         one(NRN | LA); one(BS | LC); one(LAD); one(NRD | LB); one(AS | LC); wait_st(CWR, mw);
      end else begin
         halts = 1'b1;
         repeat (20) one(HLT);
      end
   endtask

   function automatic int count_bit(input int from, input int b);
      int n = 0;
      for (int i = from; i < plan.size(); i++) n += int'(plan[i].v[b]);
      return n;
   endfunction

   initial begin
      int n0, n1, k, sel;
      logic [4:0] legal[8];
      logic [4:0] ins;
      legal = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00};
      #1 reset = 1'b0;
      #1 pin("reset_async_outputs", int'(act), int'(RPC | LPC));
      c_opc = 3'b000;
      c_op = 2'b00;
      rst();
      n0 = plan.size(); add(3'b110, 2'b10, 0, 0);
      pin("mov_imm_cycles", plan.size() - n0, 5);
      pin("mov_imm_write_cycle5", int'(plan[n0 + 4].v), 32'h01202);
      n0 = plan.size(); add(3'b101, 2'b00, 0, 0);
      pin("add_cycles", plan.size() - n0, 8);
      pin("add_loada_cycle5", int'(plan[n0 + 4].v), 32'h01080);
      pin("add_write_cycle8", int'(plan[n0 + 7].v), 32'h00802);
      n0 = plan.size(); add(3'b101, 2'b01, 0, 0);
      pin("cmp_cycles", plan.size() - n0, 7);
      pin("cmp_writes", count_bit(n0, 1), 0);
      n0 = plan.size(); add(3'b110, 2'b00, 0, 0);
      pin("movr_cycles", plan.size() - n0, 7);
      add(3'b101, 2'b11, 1, 0);
      add(3'b101, 2'b10, 0, 0);
      n0 = plan.size(); add(3'b011, 2'b00, 0, 0);
      n1 = plan.size(); add(3'b011, 2'b00, 3, 2);
      pin("ldr_stall_extra", (plan.size() - n1) - (n1 - n0), 5);
      pin("ldr_writes", count_bit(n1, 1), 1);
      pin("ldr_load_ir", count_bit(n1, 16), 1);
      n0 = plan.size(); add(3'b100, 2'b00, 0, 3);
      pin("str_writes", count_bit(n0, 1), 0);
      add(3'b100, 2'b00, 0, 50);
      repeat (45) void'(plan.pop_back());
      rst();
      add(3'b111, 2'b00, 0, 0);
      rst();
      add(3'b000, 2'b00, 2, 0);
      rst();
      repeat (150) begin
         sel = $urandom_range(0, 9);
         ins = (sel < 8) ? legal[sel] : 5'($urandom_range(0, 31));
         n0 = plan.size();
         add(ins[4:2], ins[1:0], $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, plan.size() - n0 - 1);
            repeat (k) void'(plan.pop_back());
            rst();
         end else if (halts) rst();
      end
      @(posedge clk);
      #1;
      while (plan.size() > 0) begin
         cur = plan.pop_front();
         reset = cur.rn;
         mem_ready = cur.rdy;
         opcode = cur.opc;
         op = cur.op;
         chk = 1'b1;
         cyc++;
         @(posedge clk);
         #1;
      end
      chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
